// File: rtl/covid_spawn_scheduler.sv
// Spawn scheduler for a pool of covidLogic slots: paces spawn requests off the frame
// counter, grants them to the lowest free slot, and sequences each slot's launch/retire.
module covid_spawn_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int SPAWN_INTERVAL = 30,
    parameter int LAUNCH_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 gameEnable,
    input  logic [NUM_SLOTS-1:0] slotDripEnable,
    input  logic [NUM_SLOTS-1:0] slotHit,
    input  logic [NUM_SLOTS-1:0] slotOffScreen,
    output logic [NUM_SLOTS-1:0] slotClear,
    output logic [NUM_SLOTS-1:0] dripStart,
    output logic [NUM_SLOTS-1:0] covidDisapper,
    output logic [3:0]           activeCount,
    output logic                 spawnPending
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LAUNCH = 3'd2,
        S_ACTIVE = 3'd3,
        S_RETIRE = 3'd4
    } slot_state_t;

    localparam int            TW      = (LAUNCH_TIMEOUT < 2) ? 1 : $clog2(LAUNCH_TIMEOUT);
    localparam logic [TW-1:0] LT_LAST = TW'(LAUNCH_TIMEOUT - 1);
    localparam logic [7:0]    SI_LAST = 8'(SPAWN_INTERVAL - 1);

    slot_state_t          r_state [NUM_SLOTS];
    slot_state_t          w_next  [NUM_SLOTS];
    logic [TW-1:0]        r_lcnt  [NUM_SLOTS];
    logic [TW-1:0]        w_lcnt_next [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_disappear;
    logic [NUM_SLOTS-1:0] w_disappear_next;
    logic [NUM_SLOTS-1:0] w_grant;
    logic                 w_grant_any;
    logic [7:0]           r_frame_cnt;
    logic                 r_pending;
    logic                 w_req;
    logic [3:0]           w_active_cnt;
    logic [3:0]           r_active_cnt;

    // Grant arbitration works only from registered state, so a slot freed this clock is granted next clock
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_grant_any && r_pending && gameEnable && (r_state[i] == S_IDLE)) begin
                w_grant[i]  = 1'b1;
                w_grant_any = 1'b1;
            end else begin
                w_grant[i]  = 1'b0;
            end
        end
    end

    // Per-slot next-state logic
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_next[i]           = r_state[i];
            w_lcnt_next[i]      = r_lcnt[i];
            w_disappear_next[i] = 1'b0;
            case (r_state[i])
                S_IDLE: begin
                    if (w_grant[i]) begin
                        w_next[i] = S_CLEAR;
                    end else begin
                        w_next[i] = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    w_next[i]      = S_LAUNCH;
                    w_lcnt_next[i] = '0;
                end
                S_LAUNCH: begin
                    if (slotDripEnable[i]) begin
                        w_next[i] = S_ACTIVE;
                    end else if (r_lcnt[i] == LT_LAST) begin
                        w_next[i] = S_IDLE;
                    end else begin
                        w_lcnt_next[i] = r_lcnt[i] + TW'(1);
                    end
                end
                S_ACTIVE: begin
                    if (slotHit[i] || slotOffScreen[i]) begin
                        w_next[i]           = S_RETIRE;
                        w_disappear_next[i] = 1'b1;
                    end else begin
                        w_next[i] = S_ACTIVE;
                    end
                end
                S_RETIRE: begin
                    if (!slotDripEnable[i]) begin
                        w_next[i] = S_IDLE;
                    end else begin
                        w_next[i] = S_RETIRE;
                    end
                end
                default: begin
                    w_next[i] = S_IDLE;
                end
            endcase
        end
    end

    // Occupancy count of the current registered slot states
    always_comb begin
        w_active_cnt = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_state[i] != S_IDLE) begin
                w_active_cnt = w_active_cnt + 4'd1;
            end else begin
                w_active_cnt = w_active_cnt;
            end
        end
    end

    assign w_req = startOfFrame && gameEnable && (r_frame_cnt == SI_LAST);

    // Slot state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= S_IDLE;
                r_lcnt[i]  <= '0;
            end
            r_disappear <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_next[i];
                r_lcnt[i]  <= w_lcnt_next[i];
            end
            r_disappear <= w_disappear_next;
        end
    end

    // Frame pacing, the single-entry pending flag and the registered occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt  <= 8'd0;
            r_pending    <= 1'b0;
            r_active_cnt <= 4'd0;
        end else begin
            r_active_cnt <= w_active_cnt;
            if (startOfFrame && gameEnable) begin
                r_frame_cnt <= (r_frame_cnt == SI_LAST) ? 8'd0 : r_frame_cnt + 8'd1;
            end
            if (!gameEnable) begin
                r_pending <= 1'b0;
            end else if (r_pending) begin
                r_pending <= !w_grant_any;
            end else begin
                r_pending <= w_req;
            end
        end
    end

    // Moore outputs decoded straight from the slot state registers
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slotClear[i] = (r_state[i] == S_CLEAR);
            dripStart[i] = (r_state[i] == S_LAUNCH) || (r_state[i] == S_ACTIVE);
        end
    end

    assign covidDisapper = r_disappear;
    assign activeCount   = r_active_cnt;
    assign spawnPending  = r_pending;

endmodule

// File: tb/tb_covid_spawn_scheduler.sv
// Directed bench for covid_spawn_scheduler with default parameters (4 slots, 30 frames, 15-clock timeout).
module tb_covid_spawn_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic       gameEnable;
    logic [3:0] slotDripEnable;
    logic [3:0] slotHit;
    logic [3:0] slotOffScreen;
    logic [3:0] slotClear;
    logic [3:0] dripStart;
    logic [3:0] covidDisapper;
    logic [3:0] activeCount;
    logic       spawnPending;

    int checks = 0;
    int errors = 0;

    covid_spawn_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .gameEnable     (gameEnable),
        .slotDripEnable (slotDripEnable),
        .slotHit        (slotHit),
        .slotOffScreen  (slotOffScreen),
        .slotClear      (slotClear),
        .dripStart      (dripStart),
        .covidDisapper  (covidDisapper),
        .activeCount    (activeCount),
        .spawnPending   (spawnPending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_frame();
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            pulse_frame();
            tick(1);
        end
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait a full interval, then follow the grant into slot k through CLEAR, LAUNCH and into ACTIVE.
    task automatic spawn_into(input int k);
        logic [3:0] m;
        m = 4'b0001 << k;
        frames(29);
        check("pend_before_30", {3'b000, spawnPending}, 4'd0);
        pulse_frame();
        check("pend_on_30", {3'b000, spawnPending}, 4'd1);
        tick(1);
        check("clear_slot", slotClear, m);
        check("pend_cleared", {3'b000, spawnPending}, 4'd0);
        tick(1);
        check("clear_one_clock", slotClear & m, 4'd0);
        check("launch_drip", dripStart & m, m);
        slotDripEnable = slotDripEnable | m;
        tick(1);
        check("active_drip", dripStart & m, m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        startOfFrame   = 1'b0;
        gameEnable     = 1'b0;
        slotDripEnable = 4'b0000;
        slotHit        = 4'b0000;
        slotOffScreen  = 4'b0000;
        tick(2);
        check("rst_clear", slotClear, 4'd0);
        check("rst_drip", dripStart, 4'd0);
        check("rst_disappear", covidDisapper, 4'd0);
        check("rst_count", activeCount, 4'd0);
        check("rst_pending", {3'b000, spawnPending}, 4'd0);
        reset = 1'b0;
        tick(1);

        // First spawn lands in slot 0
        gameEnable = 1'b1;
        spawn_into(0);
        check("count_one", activeCount, 4'd1);

        // Hit on an idle slot is ignored; off-screen on an active slot retires it
        slotHit = 4'b0010;
        tick(1);
        slotHit = 4'b0000;
        check("hit_idle_ignored", covidDisapper, 4'd0);
        check("hit_idle_count", activeCount, 4'd1);
        slotOffScreen = 4'b0001;
        tick(1);
        check("offscreen_disappear", covidDisapper, 4'b0001);
        check("retire_drip_low", dripStart, 4'd0);
        tick(1);
        check("disappear_once", covidDisapper, 4'd0);
        slotOffScreen  = 4'b0000;
        slotDripEnable = 4'b0000;
        tick(2);
        check("retired_count", activeCount, 4'd0);

        // Fill every slot
        spawn_into(0);
        spawn_into(1);
        spawn_into(2);
        spawn_into(3);
        check("all_active_count", activeCount, 4'd4);
        check("all_active_drip", dripStart, 4'b1111);

        // Request while full waits; freed slot 2 is granted one clock after it goes idle
        frames(29);
        pulse_frame();
        tick(1);
        check("full_pending", {3'b000, spawnPending}, 4'd1);
        check("full_no_clear", slotClear, 4'd0);
        slotHit = 4'b0100;
        tick(1);
        slotHit = 4'b0000;
        check("hit2_disappear", covidDisapper, 4'b0100);
        check("hit2_drip", dripStart, 4'b1011);
        slotDripEnable = 4'b1011;
        tick(1);
        check("idle2_still_pending", {3'b000, spawnPending}, 4'd1);
        check("idle2_no_same_cycle", slotClear, 4'd0);
        tick(1);
        check("regrant_slot2", slotClear, 4'b0100);
        check("regrant_pend_clear", {3'b000, spawnPending}, 4'd0);
        tick(1);
        check("slot2_launch", dripStart, 4'b1111);

        // Slot 2 never sees dripEnable: times out after 15 clocks in LAUNCH
        tick(14);
        check("timeout_not_yet", dripStart, 4'b1111);
        check("timeout_count4", activeCount, 4'd4);
        tick(1);
        check("timeout_drip_low", dripStart, 4'b1011);
        tick(1);
        check("timeout_count3", activeCount, 4'd3);

        // Reset mid-operation with three slots active
        frames(10);
        reset = 1'b1;
        #1;
        check("mid_rst_drip", dripStart, 4'd0);
        check("mid_rst_count", activeCount, 4'd0);
        check("mid_rst_disappear", covidDisapper, 4'd0);
        check("mid_rst_pending", {3'b000, spawnPending}, 4'd0);
        tick(2);
        check("mid_rst_clear", slotClear, 4'd0);
        check("mid_rst_hold", dripStart, 4'd0);
        slotDripEnable = 4'b0000;
        reset = 1'b0;
        tick(1);
        spawn_into(0);

        // Game paused for 50 frames mid-interval: counter holds, active slot keeps running
        frames(10);
        gameEnable = 1'b0;
        frames(50);
        check("paused_no_pending", {3'b000, spawnPending}, 4'd0);
        check("paused_slot_kept", dripStart, 4'b0001);
        gameEnable = 1'b1;
        frames(19);
        check("resume_not_early", {3'b000, spawnPending}, 4'd0);
        pulse_frame();
        check("resume_on_remaining", {3'b000, spawnPending}, 4'd1);
        gameEnable = 1'b0;
        tick(1);
        check("disable_clears_pend", {3'b000, spawnPending}, 4'd0);
        check("disable_no_grant", slotClear, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/covid_spawn_scheduler.md
COVID_SPAWN_SCHEDULER -- requirements
Module: covid_spawn_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of covidLogic instances managed (2..8).
REQ-002 SHALL have parameter SPAWN_INTERVAL, default 30: startOfFrame pulses between spawn requests (1..255).
REQ-003 SHALL have parameter LAUNCH_TIMEOUT, default 15: clocks to wait for a slot's dripEnable after dripStart.
REQ-004 SHALL have port clk, input, 1: system clock; every register is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port startOfFrame, input, 1: one-clock pulse at each frame start.
REQ-007 SHALL have port gameEnable, input, 1: spawning permitted while high.
REQ-008 SHALL have port slotDripEnable, input, NUM_SLOTS: dripEnable returned by each slot.
REQ-009 SHALL have port slotHit, input, NUM_SLOTS: one-clock kill pulse per slot (collision).
REQ-010 SHALL have port slotOffScreen, input, NUM_SLOTS: level, slot is outside the playfield.
REQ-011 SHALL have port slotClear, output, NUM_SLOTS: one-clock active-high per-slot reinitialise pulse.
REQ-012 SHALL have port dripStart, output, NUM_SLOTS: per-slot launch level.
REQ-013 SHALL have port covidDisapper, output, NUM_SLOTS: per-slot one-clock disappear pulse.
REQ-014 SHALL have port activeCount, output, 4: number of slots not in IDLE.
REQ-015 SHALL have port spawnPending, output, 1: a spawn request is waiting for a free slot.

Function
REQ-016 SHALL run one state machine per slot with states IDLE, CLEAR, LAUNCH, ACTIVE and RETIRE.
REQ-017 IDLE SHALL drive all of that slot's outputs low; the slot leaves IDLE only when granted.
REQ-018 CLEAR SHALL assert slotClear[i] for exactly one clock, then go to LAUNCH.
REQ-019 LAUNCH SHALL hold dripStart[i] high and go to ACTIVE the clock after slotDripEnable[i] is seen high.
REQ-020 If LAUNCH lasts LAUNCH_TIMEOUT clocks without slotDripEnable[i], the slot SHALL go to IDLE and the request SHALL be dropped.
REQ-021 ACTIVE SHALL keep dripStart[i] high; slotHit[i] or slotOffScreen[i] SHALL pulse covidDisapper[i] for one clock and go to RETIRE.
REQ-022 RETIRE SHALL drop dripStart[i] and go to IDLE the clock after slotDripEnable[i] is seen low.
REQ-023 slotHit/slotOffScreen outside ACTIVE SHALL be ignored.
REQ-024 An 8-bit frame counter SHALL increment on startOfFrame while gameEnable=1 and hold while gameEnable=0.
REQ-025 When the counter reaches SPAWN_INTERVAL-1 on a startOfFrame it SHALL reload to 0 and set the pending flag.
REQ-026 Arbitration: while pending=1 and any slot is IDLE, the lowest-index IDLE slot SHALL be granted, enter CLEAR the next clock, and pending SHALL clear.
REQ-027 Only one slot SHALL be granted per clock.
REQ-028 A request arriving while pending=1 SHALL be merged into it (no queueing beyond one).
REQ-029 If a slot returns to IDLE in the same clock a request is set, the grant SHALL occur one clock later (no combinational same-cycle grant).
REQ-030 spawnPending SHALL equal the pending flag; activeCount SHALL be a registered count of non-IDLE slots, updated one clock after the state changes.
REQ-031 gameEnable falling SHALL clear pending; active slots SHALL continue unaffected.

Reset
REQ-032 While reset=1, all slots SHALL be IDLE, the counter 0, pending 0, and slotClear, dripStart, covidDisapper, activeCount and spawnPending all 0.
REQ-033 Reset asserted mid-operation SHALL abandon all slots immediately, with no covidDisapper pulse emitted.

Verification
REQ-034 Bench: gameEnable=1, 30 startOfFrame pulses, no slots busy -> pending rises on pulse 30; slot0 slotClear for 1 clock; dripStart[0] high; activeCount=1.
REQ-035 Bench: all 4 slots ACTIVE, request due -> spawnPending=1; slotHit[2] then slotDripEnable[2] low -> slot2 IDLE, then granted the following clock; spawnPending=0.
REQ-036 Bench: slot in LAUNCH, slotDripEnable held low for 15 clocks -> slot IDLE, dripStart low, activeCount decrements.
REQ-037 Bench: slotHit[1] while slot1 IDLE -> no covidDisapper; slotOffScreen[0] while ACTIVE -> covidDisapper[0] pulses once, slot enters RETIRE.
REQ-038 Bench: reset pulsed with 3 slots ACTIVE -> all outputs 0 during reset; first new spawn after 30 further frames.
REQ-039 Bench: gameEnable low for 50 frames mid-interval -> counter frozen; spawn resumes at the remaining count.
